otter_intr_ctrl: RTL and testbench

// Multi-source interrupt controller feeding the OTTER control unit's single interrupt input.
// - Synchronizes NUM_SRC asynchronous lines and latches their rising edges as pending.
// - Masks and prioritizes the pending sources, then raises intr_req to the CU.
// - Sequences one interrupt at a time: int_taken/mret_exec handshake with CU and CSR (MSTATUS.MIE).

---
 rtl/otter_intr_ctrl.sv | 150 +++++++++++++++
 tb/tb_otter_intr_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: multi-source interrupt controller for the OTTER CU.
//   Synchronizes NUM_SRC async lines, latches rising edges as pending,
//   masks and prioritizes (index 0 highest), and sequences a single
//   outstanding interrupt through the CU's int_taken / mret_exec handshake.
// Ports:
//   clk, RST    - system clock, synchronous active-high reset
//   irq_in      - async level interrupt lines (rising edge = event)
//   mie         - MSTATUS.MIE global enable
//   mask_we/wd  - mask register write port (bit=1 enables source)
//   int_taken   - CU pulse: trap entered
//   mret_exec   - CU pulse: mret executed
//   intr_req    - registered request to CU
//   irq_id      - index of requested / in-service source
//   mask        - current mask register
//   pending     - pending-event register
//   busy        - high while an interrupt is in service

// Per-source synchronizer and rising-edge detector.
module otter_intr_src_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic RST,
   input  logic irq_in,
   output logic rise
);
   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk) begin
      if (RST) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], irq_in};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign rise = chain[SYNC_STAGES-1] & ~prev;
endmodule

module otter_intr_ctrl #(
   parameter  int NUM_SRC     = 8,
   parameter  int SYNC_STAGES = 2,
   localparam int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               RST,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               mie,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wd,
   input  logic               int_taken,
   input  logic               mret_exec,
   output logic               intr_req,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] mask,
   output logic [NUM_SRC-1:0] pending,
   output logic               busy
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   logic [1:0]         state;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr;
   logic [ID_W-1:0]    winner;
   logic               any_elig;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      otter_intr_src_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .RST    (RST),
         .irq_in (irq_in[i]),
         .rise   (rise[i])
      );
   end

   assign eligible = pending & mask;
   assign any_elig = |eligible;

   // Lowest set index wins: scan downward so the last hit is the smallest.
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (eligible[i]) winner = ID_W'(i);
   end

   // Only the accepted source is cleared; OR-ing rise after the clear makes
   // a coincident new event survive.
   always_comb begin
      clr = '0;
      if (state == ST_REQ && int_taken) clr[irq_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         mask    <= '0;
         pending <= '0;
      end else begin
         if (mask_we) mask <= mask_wd;
         pending <= (pending & ~clr) | rise;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state    <= ST_IDLE;
         intr_req <= 1'b0;
         irq_id   <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mie && any_elig) begin
                  state    <= ST_REQ;
                  irq_id   <= winner;
                  intr_req <= 1'b1;
               end
            end
            ST_REQ: begin
               // int_taken beats a withdraw in the same cycle; irq_id is
               // frozen until the request resolves one way or the other.
               if (int_taken) begin
                  state    <= ST_SERVICE;
                  intr_req <= 1'b0;
                  busy     <= 1'b1;
               end else if (!mie || !eligible[irq_id]) begin
                  state    <= ST_IDLE;
                  intr_req <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (mret_exec) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               intr_req <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl (defaults: 8 sources, 2-stage sync).
// Expected output snapshots are queued as each step is driven and popped
// for comparison after the clock edge that should produce them.
module tb_otter_intr_ctrl;
   logic       clk = 1'b0;
   logic       RST;
   logic [7:0] irq_in;
   logic       mie;
   logic       mask_we;
   logic [7:0] mask_wd;
   logic       int_taken;
   logic       mret_exec;
   logic       intr_req;
   logic [2:0] irq_id;
   logic [7:0] mask;
   logic [7:0] pending;
   logic       busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      tag;
      logic       req;
      logic [2:0] id;
      logic [7:0] pend;
      logic [7:0] msk;
      logic       bsy;
   } exp_t;

   exp_t sb[$];

   otter_intr_ctrl dut (
      .clk       (clk),
      .RST       (RST),
      .irq_in    (irq_in),
      .mie       (mie),
      .mask_we   (mask_we),
      .mask_wd   (mask_wd),
      .int_taken (int_taken),
      .mret_exec (mret_exec),
      .intr_req  (intr_req),
      .irq_id    (irq_id),
      .mask      (mask),
      .pending   (pending),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic req, input logic [2:0] id,
                       input logic [7:0] pend, input logic [7:0] msk, input logic bsy);
      exp_t e;
      e.tag = tag; e.req = req; e.id = id; e.pend = pend; e.msk = msk; e.bsy = bsy;
      sb.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".intr_req"}, {31'd0, intr_req}, {31'd0, e.req});
      chk({e.tag, ".irq_id"},   {29'd0, irq_id},   {29'd0, e.id});
      chk({e.tag, ".pending"},  {24'd0, pending},  {24'd0, e.pend});
      chk({e.tag, ".mask"},     {24'd0, mask},     {24'd0, e.msk});
      chk({e.tag, ".busy"},     {31'd0, busy},     {31'd0, e.bsy});
   endtask

   initial begin
      RST = 1'b1; irq_in = '0; mie = 1'b0; mask_we = 1'b0; mask_wd = '0;
      int_taken = 1'b0; mret_exec = 1'b0;
      push("reset", 0, 3'd0, 8'h00, 8'h00, 0);
      tick(2);
      pop_cmp();
      RST = 1'b0;

      // 1: single source, three-edge latency
      mask_we = 1'b1; mask_wd = 8'hFF; mie = 1'b1;
      tick();
      mask_we = 1'b0;
      irq_in = 8'h08;
      push("t1_pend_only", 0, 3'd0, 8'h08, 8'hFF, 0);
      tick(3);
      pop_cmp();
      push("t1_req", 1, 3'd3, 8'h08, 8'hFF, 0);
      tick();
      pop_cmp();

      // 2: take and return
      int_taken = 1'b1;
      push("t2_taken", 0, 3'd3, 8'h00, 8'hFF, 1);
      tick();
      pop_cmp();
      int_taken = 1'b0;
      mret_exec = 1'b1;
      push("t2_mret", 0, 3'd3, 8'h00, 8'hFF, 0);
      tick();
      pop_cmp();
      mret_exec = 1'b0;

      // 3: simultaneous 5 and 2, lowest index wins; 5 follows after mret
      irq_in = 8'h2C;
      push("t3_req2", 1, 3'd2, 8'h24, 8'hFF, 0);
      tick(4);
      pop_cmp();
      int_taken = 1'b1;
      push("t3_take2", 0, 3'd2, 8'h20, 8'hFF, 1);
      tick();
      pop_cmp();
      int_taken = 1'b0;
      push("t3_no_nest", 0, 3'd2, 8'h20, 8'hFF, 1);
      tick();
      pop_cmp();
      mret_exec = 1'b1;
      push("t3_mret", 0, 3'd2, 8'h20, 8'hFF, 0);
      tick();
      pop_cmp();
      mret_exec = 1'b0;
      push("t3_req5", 1, 3'd5, 8'h20, 8'hFF, 0);
      tick();
      pop_cmp();
      int_taken = 1'b1;
      tick();
      int_taken = 1'b0;
      mret_exec = 1'b1;
      push("t3_done", 0, 3'd5, 8'h00, 8'hFF, 0);
      tick();
      pop_cmp();
      mret_exec = 1'b0;

      // 4: masked source stays pending, unmask releases it
      mask_we = 1'b1; mask_wd = 8'h00;
      tick();
      mask_we = 1'b0;
      irq_in = 8'h2E;
      push("t4_masked", 0, 3'd5, 8'h02, 8'h00, 0);
      tick(4);
      pop_cmp();
      mask_we = 1'b1; mask_wd = 8'h02;
      push("t4_mask_wr", 0, 3'd5, 8'h02, 8'h02, 0);
      tick();
      pop_cmp();
      mask_we = 1'b0;
      push("t4_req1", 1, 3'd1, 8'h02, 8'h02, 0);
      tick();
      pop_cmp();
      int_taken = 1'b1;
      tick();
      int_taken = 1'b0;
      mret_exec = 1'b1;
      tick();
      mret_exec = 1'b0;

      // 5: mie withdraw keeps pending; int_taken beats withdraw
      mask_we = 1'b1; mask_wd = 8'hFF;
      tick();
      mask_we = 1'b0;
      irq_in = 8'h3E;
      push("t5_req4", 1, 3'd4, 8'h10, 8'hFF, 0);
      tick(4);
      pop_cmp();
      mie = 1'b0;
      push("t5_withdraw", 0, 3'd4, 8'h10, 8'hFF, 0);
      tick();
      pop_cmp();
      push("t5_stay_idle", 0, 3'd4, 8'h10, 8'hFF, 0);
      tick();
      pop_cmp();
      mie = 1'b1;
      push("t5_rereq", 1, 3'd4, 8'h10, 8'hFF, 0);
      tick();
      pop_cmp();
      mie = 1'b0; int_taken = 1'b1;
      push("t5_take_wins", 0, 3'd4, 8'h00, 8'hFF, 1);
      tick();
      pop_cmp();
      int_taken = 1'b0; mie = 1'b1;
      mret_exec = 1'b1;
      tick();
      mret_exec = 1'b0;

      // 6: new edge on 0 lands on the same edge as its int_taken clear
      irq_in = 8'h3F;
      push("t6_req0", 1, 3'd0, 8'h01, 8'hFF, 0);
      tick(4);
      pop_cmp();
      irq_in = 8'h3E;
      tick(3);
      irq_in = 8'h3F;
      tick(2);
      int_taken = 1'b1;
      push("t6_set_wins", 0, 3'd0, 8'h01, 8'hFF, 1);
      tick();
      pop_cmp();
      int_taken = 1'b0;
      RST = 1'b1;
      push("t6_reset_svc", 0, 3'd0, 8'h00, 8'h00, 0);
      tick();
      pop_cmp();
      RST = 1'b0;

      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
